mem_access_unit: RTL and testbench

- Data-memory access engine for the MEM stage. It is the narrowing/packing counterpart of the immediate and load extenders.
- Store path: narrows byte and halfword store data into little-endian byte lanes and generates byte enables.
- Load path: extracts the addressed lane from the returned word and zero- or sign-extends it to 32 bits.
- Talks to a variable-latency memory bus through a req/ack handshake. Exposes a valid/ready request port and a one-cycle response pulse to the pipeline stall logic.

---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_access_unit_load_extract.sv | 34 +++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM encoding and lane helpers for the MEM-stage access engine.
// Pure definitions; no state, no timing.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mau_state_t;

    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] en;
        case (size)
            SZ_BYTE: en = 4'b0001 << off;
            SZ_HALF: en = 4'b0011 << off;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte/half lane of a read word and zero/sign-extends it.
// Purely combinational; no backpressure.
module load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access engine: packs stores into byte lanes, extends loads, runs a req/ack bus cycle with timeout.
// Accept N, ack N+1 -> resp_valid N+2; req_ready only in IDLE, so one access is in flight at a time.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_sign,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_byteen,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);

    localparam int CNT_W = 8;

    mau_state_t        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [1:0]        r_addr_lo;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [31:0]       r_bus_addr;
    logic [3:0]        r_bus_byteen;
    logic [31:0]       r_bus_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [31:0]       w_load_data;

    load_extract u_load_extract (
        .i_rdata   (i_bus_rdata),
        .i_addr_lo (r_addr_lo),
        .i_size    (r_size),
        .i_sign    (r_sign),
        .o_data    (w_load_data)
    );

    // Gated by reset so the pipeline never sees ready while the unit is held.
    assign o_req_ready = (r_state == ST_IDLE) && !i_reset;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_sign       <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_cnt        <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_byteen <= '0;
            r_bus_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (i_req_valid) begin
                        r_we         <= i_req_we;
                        r_size       <= i_req_size;
                        r_sign       <= i_req_sign;
                        r_addr_lo    <= i_req_addr[1:0];
                        r_cnt        <= '0;
                        r_resp_rdata <= '0;
                        if (is_illegal(i_req_size, i_req_addr[1:0])) begin
                            r_resp_err <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_resp_err   <= 1'b0;
                            r_bus_req    <= 1'b1;
                            r_bus_we     <= i_req_we;
                            r_bus_addr   <= {i_req_addr[31:2], 2'b00};
                            r_bus_byteen <= lane_en(i_req_size, i_req_addr[1:0]);
                            r_bus_wdata  <= store_lanes(i_req_size, i_req_wdata);
                            r_state      <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // An ack in the timeout cycle wins: it is tested first.
                    if (i_bus_ack) begin
                        r_bus_req    <= 1'b0;
                        r_resp_rdata <= r_we ? 32'h0 : w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_bus_req    <= 1'b0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Rejected requests arrive with the pulse not yet raised and spend one staging cycle here.
                    if (r_resp_valid) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_resp_valid <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_bus_req    = r_bus_req;
    assign o_bus_we     = r_bus_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_byteen = r_bus_byteen;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_sign;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_byteen;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_size   (i_req_size),
        .i_req_sign   (i_req_sign),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_byteen (o_bus_byteen),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_ack    (i_bus_ack),
        .i_bus_rdata  (i_bus_rdata),
        .o_resp_valid (o_resp_valid),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_err   (o_resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Reference load result: shift the lane down, mask to width, fill upper bits from the top bit if signed.
    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                               input logic [1:0] off, input logic [31:0] rdata);
        int          nb;
        int          bits;
        logic [63:0] mask;
        logic [63:0] v;
        nb   = size_bytes(size);
        bits = 8 * nb;
        mask = (64'd1 << bits) - 64'd1;
        v    = ({32'd0, rdata} >> (8 * int'(off))) & mask;
        if (sign && nb < 4 && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input int ack_dly,
                       input logic [31:0] rdata);
        int          nb;
        logic        ill;
        logic        tmo;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] exp_addr;
        int          waits;
        int          cycles;
        int          bus_hi;
        logic        got;
        logic        stable;
        logic        err_s;
        logic [31:0] rd_s;

        nb       = size_bytes(size);
        ill      = (size == 2'd3) || ((int'(addr[1:0]) % nb) != 0);
        tmo      = !ill && (ack_dly == 0 || ack_dly > TMO);
        exp_be   = 4'(((1 << nb) - 1) << int'(addr[1:0]));
        exp_wd   = (nb == 1) ? {24'd0, wdata[7:0]} * 32'h01010101 :
                   (nb == 2) ? {16'd0, wdata[15:0]} * 32'h00010001 : wdata;
        exp_rd   = (ill || tmo || we) ? 32'd0 : model_load(size, sign, addr[1:0], rdata);
        exp_addr = {addr[31:2], 2'b00};

        @(negedge clk);
        waits = 0;
        while (!o_req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "/ready"}, 32'(o_req_ready), 32'd1);

        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_size  = size;
        i_req_sign  = sign;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_req_we    = 1'($urandom);
        i_req_size  = 2'($urandom);
        i_req_sign  = 1'($urandom);
        i_req_addr  = $urandom;
        i_req_wdata = $urandom;

        cycles = 0;
        bus_hi = 0;
        got    = 1'b0;
        stable = 1'b1;
        err_s  = 1'b0;
        rd_s   = 32'd0;
        while (!got && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (o_resp_valid) begin
                got       = 1'b1;
                err_s     = o_resp_err;
                rd_s      = o_resp_rdata;
                i_bus_ack = 1'b0;
            end else if (o_bus_req) begin
                bus_hi++;
                if (o_bus_addr !== exp_addr || o_bus_we !== we || o_bus_byteen !== exp_be ||
                    (we && o_bus_wdata !== exp_wd))
                    stable = 1'b0;
                i_bus_ack   = (bus_hi == ack_dly);
                i_bus_rdata = i_bus_ack ? rdata : $urandom;
            end else begin
                i_bus_ack   = 1'($urandom);
                i_bus_rdata = $urandom;
            end
        end

        check({tag, "/resp_seen"}, 32'(got), 32'd1);
        check({tag, "/latency"}, 32'(cycles), ill ? 32'd2 : tmo ? 32'(TMO + 1) : 32'(ack_dly + 1));
        check({tag, "/bus_cycles"}, 32'(bus_hi), ill ? 32'd0 : tmo ? 32'(TMO) : 32'(ack_dly));
        if (bus_hi > 0) check({tag, "/bus_fields"}, 32'(stable), 32'd1);
        check({tag, "/err"}, 32'(err_s), 32'(ill || tmo));
        check({tag, "/rdata"}, rd_s, exp_rd);

        @(negedge clk);
        i_bus_ack = 1'b0;
        check({tag, "/pulse_end"}, 32'(o_resp_valid), 32'd0);
        check({tag, "/ready_again"}, 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_size  = 2'd0;
        i_req_sign  = 1'b0;
        i_req_addr  = 32'd0;
        i_req_wdata = 32'd0;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'd0;

        repeat (2) @(negedge clk);
        check("rst/bus_req", 32'(o_bus_req), 32'd0);
        check("rst/bus_we", 32'(o_bus_we), 32'd0);
        check("rst/bus_addr", o_bus_addr, 32'd0);
        check("rst/bus_byteen", 32'(o_bus_byteen), 32'd0);
        check("rst/bus_wdata", o_bus_wdata, 32'd0);
        check("rst/resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst/resp_rdata", o_resp_rdata, 32'd0);
        check("rst/resp_err", 32'(o_resp_err), 32'd0);
        check("rst/ready_held", 32'(o_req_ready), 32'd0);
        i_reset = 1'b0;
        #1;
        check("rst/ready_release", 32'(o_req_ready), 32'd1);

        txn("sb",      1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 3, 32'hDEAD_BEEF);
        txn("lb",      1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0,         1, 32'h1122_F344);
        txn("lbu",     1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0,         2, 32'h1122_F344);
        txn("lh",      1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0,         1, 32'h8001_1234);
        txn("lhu",     1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,         1, 32'h8001_1234);
        txn("lw_mis",  1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0,         1, 32'h1234_5678);
        txn("size3",   1'b1, 2'd3, 1'b0, 32'h0000_3000, 32'h5555_AAAA, 1, 32'h0);
        txn("sh_mis",  1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'h0000_BEEF, 1, 32'h0);
        txn("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,         0, 32'h0);
        txn("after_to",1'b0, 2'd2, 1'b1, 32'h0000_4004, 32'h0,         1, 32'h8765_4321);
        txn("ack_edge",1'b1, 2'd2, 1'b0, 32'h0000_4008, 32'hCAFE_F00D, TMO, 32'h0);
        txn("sh_hi",   1'b1, 2'd1, 1'b0, 32'h0000_500E, 32'h1234_ABCD, 2, 32'h0);

        // Reset while a bus cycle is outstanding.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_size  = 2'd2;
        i_req_addr  = 32'h0000_0040;
        i_req_wdata = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("midrst/in_bus", 32'(o_bus_req), 32'd1);
        i_reset = 1'b1;
        #1;
        check("midrst/bus_req_drop", 32'(o_bus_req), 32'd0);
        check("midrst/ready_held", 32'(o_req_ready), 32'd0);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            check("midrst/no_resp", 32'(o_resp_valid), 32'd0);
        end
        i_reset = 1'b0;
        #1;
        check("midrst/ready_release", 32'(o_req_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("midrst/stale_ack_resp", 32'(o_resp_valid), 32'd0);
            check("midrst/stale_ack_bus", 32'(o_bus_req), 32'd0);
        end
        i_bus_ack = 1'b0;
        txn("post_rst", 1'b0, 2'd0, 1'b1, 32'h0000_0043, 32'h0, 1, 32'h80FF_0000);

        for (int k = 0; k < 80; k++) begin
            logic [1:0]  r_size;
            logic [31:0] r_addr;
            r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'd1) r_addr[0] = 1'b0;
                if (r_size == 2'd2) r_addr[1:0] = 2'b00;
            end
            txn($sformatf("rnd%0d", k), 1'($urandom), r_size, 1'($urandom), r_addr, $urandom,
                $urandom_range(0, TMO + 2), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
